// File: rtl/multitap_pkg.sv
// Shared types and keypad constants for the multi-tap text entry block.
// Key codes are {row, col} one-hot. Row 0 and column 0 are the 4'b1000 end.
package multitap_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam logic [7:0] KEY_1    = 8'h88;
    localparam logic [7:0] KEY_2    = 8'h84;
    localparam logic [7:0] KEY_3    = 8'h82;
    localparam logic [7:0] KEY_A    = 8'h81;
    localparam logic [7:0] KEY_4    = 8'h48;
    localparam logic [7:0] KEY_5    = 8'h44;
    localparam logic [7:0] KEY_6    = 8'h42;
    localparam logic [7:0] KEY_B    = 8'h41;
    localparam logic [7:0] KEY_7    = 8'h28;
    localparam logic [7:0] KEY_8    = 8'h24;
    localparam logic [7:0] KEY_9    = 8'h22;
    localparam logic [7:0] KEY_C    = 8'h21;
    localparam logic [7:0] KEY_STAR = 8'h18;
    localparam logic [7:0] KEY_0    = 8'h14;
    localparam logic [7:0] KEY_HASH = 8'h12;
    localparam logic [7:0] KEY_D    = 8'h11;

    // Number of letters on a key. A result of 0 means the key is not a letter key.
    function automatic logic [2:0] taps_per_key(input logic [7:0] kc);
        case (kc)
            KEY_7, KEY_9:                             taps_per_key = 3'd4;
            KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_8: taps_per_key = 3'd3;
            default:                                  taps_per_key = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/multitap_encoder.sv
// Combinational map from (letter key, tap index) to uppercase ASCII.
// Any key that is not a letter key gives 0.
module multitap_encoder
    import multitap_pkg::*;
(
    input  logic [7:0] key_code,
    input  logic [1:0] tap,
    output logic [7:0] ascii
);

    logic [7:0] base;

    always_comb begin
        base = 8'd0;
        case (key_code)
            KEY_2:   base = "A";
            KEY_3:   base = "D";
            KEY_4:   base = "G";
            KEY_5:   base = "J";
            KEY_6:   base = "M";
            KEY_7:   base = "P";
            KEY_8:   base = "T";
            KEY_9:   base = "W";
            default: base = 8'd0;
        endcase
        ascii = (base == 8'd0) ? 8'd0 : base + {6'd0, tap};
    end

endmodule

// File: rtl/multitap_entry.sv
// Multi-tap phone-keypad text entry. It cycles letters on repeated presses and builds a word buffer.
// The buffer is submitted as a word on '#'. Every output comes straight from a flop.
module multitap_entry
    import multitap_pkg::*;
#(
    parameter int WORD_LEN    = 5,
    parameter int TIMEOUT_CYC = 12000000,
    parameter int CNT_W       = 24
) (
    input  logic                           clk,
    input  logic                           nRst,
    input  logic                           strobe,
    input  logic [7:0]                     key_code,
    output logic [7:0]                     preview,
    output logic                           letter_valid,
    output logic [7:0]                     letter,
    output logic [8*WORD_LEN-1:0]          word,
    output logic [$clog2(WORD_LEN+1)-1:0]  word_len,
    output logic                           word_valid,
    output logic                           overflow,
    output logic                           game_end
);

    localparam int               LEN_W      = $clog2(WORD_LEN + 1);
    localparam int               BUF_W      = 8 * WORD_LEN;
    localparam logic [LEN_W-1:0] FULL       = LEN_W'(WORD_LEN);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_e           state_q, state_d;
    logic [7:0]       key_q, key_d;
    logic [1:0]       tap_q, tap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [7:0]       preview_q, preview_d;
    logic [7:0]       letter_q, letter_d;
    logic [BUF_W-1:0] word_q, word_d;
    logic [LEN_W-1:0] word_len_q, word_len_d;
    logic             letter_valid_q, letter_valid_d;
    logic             word_valid_q, word_valid_d;
    logic             overflow_q, overflow_d;
    logic             game_end_q, game_end_d;

    logic       expired, pending, commit, submit, drop_last, wipe, restart_cnt;
    logic [2:0] taps;
    logic [7:0] next_char;

    multitap_encoder u_encoder (
        .key_code (key_d),
        .tap      (tap_d),
        .ascii    (next_char)
    );

    assign preview_d = (state_d == ST_PENDING) ? next_char : 8'd0;

    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        tap_d          = tap_q;
        buf_d          = buf_q;
        count_d        = count_q;
        letter_d       = letter_q;
        word_d         = word_q;
        word_len_d     = word_len_q;
        letter_valid_d = 1'b0;
        word_valid_d   = 1'b0;
        overflow_d     = 1'b0;
        game_end_d     = 1'b0;
        submit         = 1'b0;
        drop_last      = 1'b0;
        wipe           = 1'b0;
        restart_cnt    = 1'b0;
        taps           = taps_per_key(key_code);

        // A timeout commits first. A strobe in that same cycle then sees an IDLE machine.
        expired = TIMEOUT_EN && (state_q == ST_PENDING) && (cnt_q == CNT_LAST);
        pending = (state_q == ST_PENDING) && !expired;
        commit  = expired;
        if (expired) state_d = ST_IDLE;

        if (strobe) begin
            case (key_code)
                KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: begin
                    restart_cnt = 1'b1;
                    state_d     = ST_PENDING;
                    if (pending && key_code == key_q) begin
                        tap_d = (3'(tap_q) == taps - 3'd1) ? 2'd0 : tap_q + 2'd1;
                    end else begin
                        commit = commit | pending;
                        key_d  = key_code;
                        tap_d  = 2'd0;
                    end
                end
                KEY_STAR: begin
                    if (pending) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                KEY_0: begin
                    if (pending) state_d = ST_IDLE;
                    else drop_last = 1'b1;
                end
                KEY_HASH: begin
                    if (pending) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    submit = 1'b1;
                end
                KEY_C: wipe = 1'b1;
                KEY_1, KEY_A, KEY_B, KEY_D: ;
                default: ;
            endcase
        end

        // preview_q always holds the ASCII of the letter being committed.
        if (commit) begin
            if (count_d < FULL) begin
                for (int i = 0; i < WORD_LEN; i++) begin
                    if (count_d == LEN_W'(i)) buf_d[8*i +: 8] = preview_q;
                end
                count_d        = count_d + 1'b1;
                letter_d       = preview_q;
                letter_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (drop_last && count_d != '0) begin
            count_d = count_d - 1'b1;
            for (int i = 0; i < WORD_LEN; i++) begin
                if (count_d == LEN_W'(i)) buf_d[8*i +: 8] = 8'd0;
            end
        end

        if (submit && count_d != '0) begin
            word_d       = buf_d;
            word_len_d   = count_d;
            word_valid_d = 1'b1;
            buf_d        = '0;
            count_d      = '0;
        end

        if (wipe) begin
            state_d    = ST_IDLE;
            buf_d      = '0;
            count_d    = '0;
            game_end_d = 1'b1;
        end

        if (state_d == ST_IDLE) begin
            key_d = 8'd0;
            tap_d = 2'd0;
        end

        if (state_d != ST_PENDING || restart_cnt || !TIMEOUT_EN) cnt_d = '0;
        else cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= ST_IDLE;
            key_q          <= '0;
            tap_q          <= '0;
            cnt_q          <= '0;
            buf_q          <= '0;
            count_q        <= '0;
            preview_q      <= '0;
            letter_q       <= '0;
            word_q         <= '0;
            word_len_q     <= '0;
            letter_valid_q <= 1'b0;
            word_valid_q   <= 1'b0;
            overflow_q     <= 1'b0;
            game_end_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            tap_q          <= tap_d;
            cnt_q          <= cnt_d;
            buf_q          <= buf_d;
            count_q        <= count_d;
            preview_q      <= preview_d;
            letter_q       <= letter_d;
            word_q         <= word_d;
            word_len_q     <= word_len_d;
            letter_valid_q <= letter_valid_d;
            word_valid_q   <= word_valid_d;
            overflow_q     <= overflow_d;
            game_end_q     <= game_end_d;
        end
    end

    assign preview      = preview_q;
    assign letter_valid = letter_valid_q;
    assign letter       = letter_q;
    assign word         = word_q;
    assign word_len     = word_len_q;
    assign word_valid   = word_valid_q;
    assign overflow     = overflow_q;
    assign game_end     = game_end_q;

endmodule

// File: tb/tb_multitap_entry.sv
// Bench for multitap_entry. It runs directed keypad scenarios and then random key streams.
// The random streams are checked against a string/queue model of the entry rules.
module tb_multitap_entry;

    localparam int WL = 2;
    localparam int TO = 8;
    localparam int CW = 4;

    localparam logic [7:0] K1 = 8'h88, K2 = 8'h84, K3 = 8'h82, KA = 8'h81;
    localparam logic [7:0] K4 = 8'h48, K5 = 8'h44, K6 = 8'h42, KB = 8'h41;
    localparam logic [7:0] K7 = 8'h28, K8 = 8'h24, K9 = 8'h22, KC = 8'h21;
    localparam logic [7:0] KS = 8'h18, K0 = 8'h14, KH = 8'h12, KD = 8'h11;

    logic            clk = 1'b0;
    logic            nRst;
    logic            strobe;
    logic [7:0]      key_code;
    logic [7:0]      preview;
    logic            letter_valid;
    logic [7:0]      letter;
    logic [8*WL-1:0] word;
    logic [1:0]      word_len;
    logic            word_valid;
    logic            overflow;
    logic            game_end;

    int n_checks = 0;
    int n_pass   = 0;

    multitap_entry #(.WORD_LEN(WL), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .strobe       (strobe),
        .key_code     (key_code),
        .preview      (preview),
        .letter_valid (letter_valid),
        .letter       (letter),
        .word         (word),
        .word_len     (word_len),
        .word_valid   (word_valid),
        .overflow     (overflow),
        .game_end     (game_end)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: pending letter, tap, idle counter and the buffer as a byte queue.
    bit               m_pend;
    logic [7:0]       m_key;
    int               m_tap;
    int               m_cnt;
    byte unsigned     m_buf[$];
    logic [7:0]       e_preview, e_letter;
    logic             e_lv, e_wv, e_ovf, e_ge;
    logic [8*WL-1:0]  e_word;
    logic [1:0]       e_wlen;

    function automatic string letters_of(input logic [7:0] c);
        case (c)
            K2: return "ABC";
            K3: return "DEF";
            K4: return "GHI";
            K5: return "JKL";
            K6: return "MNO";
            K7: return "PQRS";
            K8: return "TUV";
            K9: return "WXYZ";
            default: return "";
        endcase
    endfunction

    task m_reset();
        m_pend = 0; m_key = 0; m_tap = 0; m_cnt = 0; m_buf.delete();
        e_preview = 0; e_letter = 0; e_lv = 0; e_wv = 0; e_ovf = 0; e_ge = 0;
        e_word = 0; e_wlen = 0;
    endtask

    task m_commit();
        string s;
        byte unsigned ch;
        s  = letters_of(m_key);
        ch = s.getc(m_tap);
        if (m_buf.size() < WL) begin
            m_buf.push_back(ch);
            e_lv = 1; e_letter = ch;
        end else begin
            e_ovf = 1;
        end
    endtask

    task m_step(input logic s, input logic [7:0] c);
        string ls, ps;
        bit pend;
        e_lv = 0; e_wv = 0; e_ovf = 0; e_ge = 0;
        pend = m_pend;
        if (pend && m_cnt == TO - 1) begin
            m_commit();
            pend = 0;
        end
        ls = letters_of(c);
        if (s) begin
            if (ls.len() > 0) begin
                if (pend && c == m_key) m_tap = (m_tap + 1) % ls.len();
                else begin
                    if (pend) m_commit();
                    m_key = c; m_tap = 0;
                end
                pend = 1;
            end else if (c == KS) begin
                if (pend) begin m_commit(); pend = 0; end
            end else if (c == K0) begin
                if (pend) pend = 0;
                else if (m_buf.size() > 0) void'(m_buf.pop_back());
            end else if (c == KH) begin
                if (pend) begin m_commit(); pend = 0; end
                if (m_buf.size() > 0) begin
                    e_word = 0;
                    for (int i = 0; i < m_buf.size(); i++) e_word[8*i +: 8] = m_buf[i];
                    e_wlen = 2'(m_buf.size());
                    e_wv = 1;
                    m_buf.delete();
                end
            end else if (c == KC) begin
                pend = 0; m_buf.delete(); e_ge = 1;
            end
        end
        m_cnt  = (!pend || (s && ls.len() > 0)) ? 0 : m_cnt + 1;
        m_pend = pend;
        if (pend) begin
            ps = letters_of(m_key);
            e_preview = ps.getc(m_tap);
        end else begin
            e_preview = 0;
        end
    endtask

    task tick(input logic s, input logic [7:0] c);
        @(negedge clk);
        strobe = s; key_code = c;
        @(posedge clk);
        m_step(s, c);
        #1;
    endtask

    task apply_reset();
        strobe = 0; key_code = 0; nRst = 0;
        repeat (2) @(posedge clk);
        m_reset();
        @(negedge clk);
        nRst = 1;
    endtask

    task test_reset();
        strobe = 0; key_code = 0; nRst = 0;
        @(posedge clk); #1;
        n_checks++; if (preview !== 8'h00) $display("FAIL reset_preview got %h want 00", preview); else n_pass++;
        n_checks++; if ({letter, word, word_len} !== '0) $display("FAIL reset_data got %h/%h/%h want 0", letter, word, word_len); else n_pass++;
        n_checks++; if ({letter_valid, word_valid, overflow, game_end} !== 4'b0) $display("FAIL reset_pulses got %b want 0000", {letter_valid, word_valid, overflow, game_end}); else n_pass++;
        m_reset();
        @(negedge clk); nRst = 1;
    endtask

    task test_cycle_seven();
        logic [7:0] want;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, K7);
            want = 8'h50 + 8'(i);
            n_checks++; if (preview !== want) $display("FAIL seven_preview tap %0d got %h want %h", i, preview, want); else n_pass++;
        end
        tick(1, KS);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h53) $display("FAIL seven_commit got v=%b l=%h want v=1 l=53", letter_valid, letter); else n_pass++;
        n_checks++; if (preview !== 8'h00) $display("FAIL seven_preview_clear got %h want 00", preview); else n_pass++;
        tick(0, 8'h00);
        n_checks++; if (letter_valid !== 1'b0 || letter !== 8'h53) $display("FAIL seven_hold got v=%b l=%h want v=0 l=53", letter_valid, letter); else n_pass++;
    endtask

    task test_wrap();
        apply_reset();
        repeat (4) tick(1, K2);
        n_checks++; if (preview !== 8'h41) $display("FAIL wrap_preview got %h want 41", preview); else n_pass++;
        tick(1, K3);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h41) $display("FAIL wrap_commit got v=%b l=%h want v=1 l=41", letter_valid, letter); else n_pass++;
        n_checks++; if (preview !== 8'h44) $display("FAIL wrap_newkey got %h want 44", preview); else n_pass++;
    endtask

    task test_timeout();
        apply_reset();
        tick(1, K5);
        repeat (7) tick(0, 8'h00);
        n_checks++; if (letter_valid !== 1'b0 || preview !== 8'h4a) $display("FAIL timeout_early got v=%b p=%h want v=0 p=4a", letter_valid, preview); else n_pass++;
        tick(0, 8'h00);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h4a || preview !== 8'h00) $display("FAIL timeout_commit got v=%b l=%h p=%h want 1 4a 00", letter_valid, letter, preview); else n_pass++;
        tick(1, K5);
        repeat (7) tick(0, 8'h00);
        tick(1, K5);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h4a || preview !== 8'h4a) $display("FAIL timeout_strobe got v=%b l=%h p=%h want 1 4a 4a", letter_valid, letter, preview); else n_pass++;
        tick(0, 8'h00);
        n_checks++; if (letter_valid !== 1'b0 || preview !== 8'h4a) $display("FAIL timeout_restart got v=%b p=%h want 0 4a", letter_valid, preview); else n_pass++;
    endtask

    task test_overflow();
        apply_reset();
        tick(1, K2); tick(1, KS);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h41) $display("FAIL ovf_first got v=%b l=%h want 1 41", letter_valid, letter); else n_pass++;
        repeat (2) tick(1, K2);
        tick(1, KS);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h42) $display("FAIL ovf_second got v=%b l=%h want 1 42", letter_valid, letter); else n_pass++;
        repeat (3) tick(1, K2);
        tick(1, KS);
        n_checks++; if (overflow !== 1'b1 || letter_valid !== 1'b0) $display("FAIL ovf_pulse got o=%b v=%b want o=1 v=0", overflow, letter_valid); else n_pass++;
        tick(0, 8'h00);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_single got %b want 0", overflow); else n_pass++;
        tick(1, KH);
        n_checks++; if (word_valid !== 1'b1 || word !== 16'h4241 || word_len !== 2'd2) $display("FAIL ovf_word got v=%b w=%h n=%0d want 1 4241 2", word_valid, word, word_len); else n_pass++;
        tick(0, 8'h00);
        n_checks++; if (word_valid !== 1'b0 || word !== 16'h4241) $display("FAIL ovf_word_hold got v=%b w=%h want 0 4241", word_valid, word); else n_pass++;
    endtask

    task test_clear();
        apply_reset();
        tick(1, K2); tick(1, KS);
        tick(1, K2); tick(1, K2); tick(1, KS);
        tick(1, K0);
        tick(1, K4);
        n_checks++; if (preview !== 8'h47) $display("FAIL clear_preview got %h want 47", preview); else n_pass++;
        tick(1, KH);
        n_checks++; if (word_valid !== 1'b1 || word !== 16'h4741 || word_len !== 2'd2) $display("FAIL clear_word got v=%b w=%h n=%0d want 1 4741 2", word_valid, word, word_len); else n_pass++;
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h47) $display("FAIL clear_commit got v=%b l=%h want 1 47", letter_valid, letter); else n_pass++;
    endtask

    task test_ignored();
        apply_reset();
        tick(1, KS);
        tick(1, KH);
        n_checks++; if ({letter_valid, word_valid, preview} !== 10'd0) $display("FAIL idle_ignore got v=%b w=%b p=%h want 0 0 00", letter_valid, word_valid, preview); else n_pass++;
        tick(1, K8);
        tick(1, K1); tick(1, KA); tick(1, KB); tick(1, KD);
        n_checks++; if (preview !== 8'h54 || letter_valid !== 1'b0) $display("FAIL ignore_keys got p=%h v=%b want 54 0", preview, letter_valid); else n_pass++;
        tick(1, KS);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h54) $display("FAIL ignore_commit got v=%b l=%h want 1 54", letter_valid, letter); else n_pass++;
    endtask

    task test_reset_mid();
        apply_reset();
        tick(1, K6);
        n_checks++; if (preview !== 8'h4d) $display("FAIL mid_preview got %h want 4d", preview); else n_pass++;
        strobe = 0;
        #2 nRst = 0;
        #1;
        n_checks++; if ({preview, letter_valid, letter, word, word_len, word_valid, overflow, game_end} !== '0) $display("FAIL mid_async got p=%h l=%h w=%h", preview, letter, word); else n_pass++;
        m_reset();
        @(negedge clk); nRst = 1;
        tick(0, 8'h00);
        n_checks++; if ({preview, letter_valid, letter, word, word_len, word_valid, overflow, game_end} !== '0) $display("FAIL mid_after got p=%h v=%b l=%h", preview, letter_valid, letter); else n_pass++;
        tick(1, KC);
        n_checks++; if (game_end !== 1'b1 || letter_valid !== 1'b0) $display("FAIL mid_game_end got g=%b v=%b want 1 0", game_end, letter_valid); else n_pass++;
        tick(0, 8'h00);
        n_checks++; if (game_end !== 1'b0 || letter_valid !== 1'b0) $display("FAIL mid_game_end_once got g=%b v=%b want 0 0", game_end, letter_valid); else n_pass++;
    endtask

    task test_random();
        logic [7:0] letter_keys [4];
        logic [7:0] dead_keys [4];
        logic [7:0] c;
        logic       s;
        int         r;
        letter_keys = '{K2, K3, K7, K9};
        dead_keys   = '{K1, KA, KB, KD};
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 99);
            if (r < 45)      c = letter_keys[$urandom_range(0, 3)];
            else if (r < 58) c = KS;
            else if (r < 68) c = K0;
            else if (r < 80) c = KH;
            else if (r < 83) c = KC;
            else if (r < 93) c = dead_keys[$urandom_range(0, 3)];
            else             c = 8'($urandom);
            tick(s, c);
            n_checks++;
            if ({preview, letter_valid, letter, word, word_len, word_valid, overflow, game_end} !==
                {e_preview, e_lv, e_letter, e_word, e_wlen, e_wv, e_ovf, e_ge})
                $display("FAIL random cyc %0d got %h want %h", cyc,
                         {preview, letter_valid, letter, word, word_len, word_valid, overflow, game_end},
                         {e_preview, e_lv, e_letter, e_word, e_wlen, e_wv, e_ovf, e_ge});
            else n_pass++;
        end
    endtask

    initial begin
        strobe = 0; key_code = 0; nRst = 1;
        m_reset();
        test_reset();
        test_cycle_seven();
        test_wrap();
        test_timeout();
        test_overflow();
        test_clear();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
